// File: rtl/parking_keypad_entry_if.sv
// Password channel between the keypad entry unit (master) and the parking
// controller (slave): two digits under valid/ready plus the verdict strobe.
interface parking_keypad_entry_if;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pwd_valid;
    logic       pwd_ready;
    logic       pwd_result_valid;
    logic       pwd_result_ok;

    modport master (
        output password_1, password_2, pwd_valid,
        input  pwd_ready, pwd_result_valid, pwd_result_ok
    );

    modport slave (
        input  password_1, password_2, pwd_valid,
        output pwd_ready, pwd_result_valid, pwd_result_ok
    );
endinterface

// File: rtl/parking_keypad_entry.sv
// Keypad password entry: two digits + enter, sent over valid/ready, then waits
// for the verdict. Define PARKING_KEYPAD_LOCKOUT_EN to lock after MAX_TRIES fails.
module parking_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 5000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sensor_entrance,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    parking_keypad_entry_if.master        pwd,
    output logic [1:0]                    digit_count,
    output logic                          key_error,
    output logic                          locked
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, DIGIT1, DIGIT2, WAIT_ENTER, SEND, RESULT, LOCKOUT
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      pw1, pw1_nxt, pw2, pw2_nxt, cnt_nxt;
    logic            err_nxt;
    logic [TO_W-1:0] idle_cnt, idle_cnt_nxt;
    logic            fail_lock, lock_done;
    logic            key_digit, key_clear, key_enter;

    assign key_digit = (key_code <= 4'd3);
    assign key_clear = (key_code == 4'hC);
    assign key_enter = (key_code == 4'hE);

`ifdef PARKING_KEYPAD_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int LK_W  = $clog2(LOCK_CYCLES + 1);

    logic [TRY_W-1:0] tries;
    logic [LK_W-1:0]  lock_cnt;
    logic             verdict;

    assign verdict   = (state == RESULT) && pwd.pwd_result_valid;
    assign fail_lock = ((TRY_W+1)'(tries) + (TRY_W+1)'(1)) == (TRY_W+1)'(MAX_TRIES);
    assign lock_done = (state == LOCKOUT) && (lock_cnt == LK_W'(LOCK_CYCLES - 1));
    assign locked    = (state == LOCKOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            tries    <= '0;
            lock_cnt <= '0;
        end else begin
            if ((verdict && pwd.pwd_result_ok) || lock_done)
                tries <= '0;
            else if (verdict && tries != TRY_W'(MAX_TRIES))
                tries <= tries + TRY_W'(1);
            lock_cnt <= (state == LOCKOUT) ? lock_cnt + LK_W'(1) : '0;
        end
    end
`else
    assign fail_lock = 1'b0;
    assign lock_done = 1'b0;
    assign locked    = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        pw1_nxt      = pw1;
        pw2_nxt      = pw2;
        cnt_nxt      = digit_count;
        err_nxt      = 1'b0;
        idle_cnt_nxt = '0;
        case (state)
            IDLE: if (sensor_entrance) state_nxt = DIGIT1;
            DIGIT1, DIGIT2, WAIT_ENTER: begin
                // Sensor drop beats any key; a key beats an expiring timeout.
                if (!sensor_entrance) begin
                    state_nxt = IDLE;
                    pw1_nxt = '0; pw2_nxt = '0; cnt_nxt = '0;
                end else if (key_valid) begin
                    if (key_clear) begin
                        state_nxt = DIGIT1;
                        pw1_nxt = '0; pw2_nxt = '0; cnt_nxt = '0;
                    end else if (key_digit && state == DIGIT1) begin
                        state_nxt = DIGIT2;
                        pw1_nxt = key_code[1:0]; cnt_nxt = 2'd1;
                    end else if (key_digit && state == DIGIT2) begin
                        state_nxt = WAIT_ENTER;
                        pw2_nxt = key_code[1:0]; cnt_nxt = 2'd2;
                    end else if (key_enter && state == WAIT_ENTER) begin
                        state_nxt = SEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = DIGIT1;
                    pw1_nxt = '0; pw2_nxt = '0; cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + TO_W'(1);
                end
            end
            SEND: if (pwd.pwd_ready) state_nxt = RESULT;
            RESULT: if (pwd.pwd_result_valid) begin
                pw1_nxt = '0; pw2_nxt = '0; cnt_nxt = '0;
                if (pwd.pwd_result_ok) state_nxt = IDLE;
                else if (fail_lock)    state_nxt = LOCKOUT;
                else                   state_nxt = DIGIT1;
            end
            LOCKOUT: if (lock_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pw1         <= '0;
            pw2         <= '0;
            digit_count <= '0;
            key_error   <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            pw1         <= pw1_nxt;
            pw2         <= pw2_nxt;
            digit_count <= cnt_nxt;
            key_error   <= err_nxt;
            idle_cnt    <= idle_cnt_nxt;
        end
    end

    assign pwd.password_1 = pw1;
    assign pwd.password_2 = pw2;
    assign pwd.pwd_valid  = (state == SEND);
endmodule

// File: tb/tb_parking_keypad_entry.sv
// Randomized + directed bench for parking_keypad_entry against a digit-queue
// reference model; honours PARKING_KEYPAD_LOCKOUT_EN like the design.
module tb_parking_keypad_entry;
    localparam int TO = 24;
    localparam int MT = 3;
    localparam int LK = 40;
`ifdef PARKING_KEYPAD_LOCKOUT_EN
    localparam bit LOCK_EXP = 1'b1;
`else
    localparam bit LOCK_EXP = 1'b0;
`endif

    logic       clk, rst, sens, kv;
    logic [3:0] kc;
    logic [1:0] digit_count;
    logic       key_error, locked;

    parking_keypad_entry_if pif ();

    parking_keypad_entry #(.TIMEOUT_CYCLES(TO), .MAX_TRIES(MT), .LOCK_CYCLES(LK)) dut (
        .clk(clk), .reset(rst), .sensor_entrance(sens), .key_valid(kv), .key_code(kc),
        .pwd(pif), .digit_count(digit_count), .key_error(key_error), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    // Reference: entered digits as a queue plus a few session flags.
    int  m_digits[$];
    bit  m_active, m_send, m_wait, m_err;
    int  m_lock, m_idle, m_tries;

    task automatic model_step();
        m_err = 1'b0;
        if (rst) begin
            m_digits.delete(); m_active = 0; m_send = 0; m_wait = 0;
            m_lock = 0; m_idle = 0; m_tries = 0;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = 0;
        end else if (m_wait) begin
            if (pif.pwd_result_valid) begin
                m_wait = 0; m_digits.delete(); m_idle = 0;
                if (pif.pwd_result_ok) m_tries = 0;
                else begin
`ifdef PARKING_KEYPAD_LOCKOUT_EN
                    m_tries++;
                    if (m_tries == MT) m_lock = LK;
                    else m_active = 1;
`else
                    m_active = 1;
`endif
                end
            end
        end else if (m_send) begin
            if (pif.pwd_ready) begin m_send = 0; m_wait = 1; end
        end else if (!m_active) begin
            if (sens) begin m_active = 1; m_idle = 0; end
        end else if (!sens) begin
            m_active = 0; m_digits.delete(); m_idle = 0;
        end else if (kv) begin
            m_idle = 0;
            if (kc <= 4'd3) begin
                if (m_digits.size() < 2) m_digits.push_back(int'(kc));
                else m_err = 1;
            end else if (kc == 4'hC) m_digits.delete();
            else if (kc == 4'hE) begin
                if (m_digits.size() == 2) begin m_send = 1; m_active = 0; end
                else m_err = 1;
            end else m_err = 1;
        end else if (m_idle == TO - 1) begin
            m_digits.delete(); m_idle = 0;
        end else m_idle++;
    endtask

    function automatic logic [8:0] model_outs();
        logic [1:0] p1, p2, n;
        p1 = (m_digits.size() >= 1) ? 2'(m_digits[0]) : 2'd0;
        p2 = (m_digits.size() >= 2) ? 2'(m_digits[1]) : 2'd0;
        n  = 2'(m_digits.size());
        return {m_send, p1, p2, n, m_err, (m_lock > 0)};
    endfunction

    logic [8:0] dut_outs;
    assign dut_outs = {pif.pwd_valid, pif.password_1, pif.password_2, digit_count, key_error, locked};

    task automatic step(input bit s, input bit k, input logic [3:0] c,
                        input bit r, input bit v, input bit o);
        sens = s; kv = k; kc = c;
        pif.pwd_ready = r; pif.pwd_result_valid = v; pif.pwd_result_ok = o;
        @(posedge clk);
        model_step();
        #1;
        chk("outs", 16'(dut_outs), 16'(model_outs()));
    endtask

    task automatic key(input logic [3:0] c);
        step(1, 1, c, 0, 0, 0);
    endtask

    // Enter two digits, send with ready high, then deliver the verdict.
    task automatic entry(input logic [3:0] d1, input logic [3:0] d2, input bit ok);
        step(1, 0, 4'h0, 0, 0, 0);
        step(1, 0, 4'h0, 0, 0, 0);
        key(d1); key(d2);
        step(1, 1, 4'hE, 1, 0, 0);
        step(1, 0, 4'h0, 1, 0, 0);
        step(1, 0, 4'h0, 0, 1, ok);
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h0, 0, 0, 0);
        chk("reset_outs", 16'(dut_outs), 16'h0);
        rst = 1'b0;

        // Happy path
        step(1, 0, 4'h0, 0, 0, 0);
        key(4'd1); key(4'd2);
        chk("two_digits", 16'(digit_count), 16'd2);
        step(1, 1, 4'hE, 1, 0, 0);
        chk("happy_valid", 16'({pif.pwd_valid, pif.password_1, pif.password_2}), 16'b1_01_10);
        step(1, 0, 4'h0, 1, 0, 0);
        chk("happy_xfer", 16'(pif.pwd_valid), 16'd0);
        step(1, 0, 4'h0, 0, 1, 1);
        chk("happy_ok_cnt", 16'(digit_count), 16'd0);

        // Handshake hold then rejected verdict
        step(1, 0, 4'h0, 0, 0, 0);
        key(4'd3); key(4'd0);
        step(1, 1, 4'hE, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 4'h0, 0, 0, 0);
        chk("hold_valid", 16'({pif.pwd_valid, pif.password_1, pif.password_2}), 16'b1_11_00);
        step(1, 0, 4'h0, 1, 0, 0);
        chk("hold_xfer", 16'(pif.pwd_valid), 16'd0);
        step(1, 0, 4'h0, 0, 1, 0);

        // Errors and clear
        key(4'd2);
        key(4'hE);
        chk("enter_early_err", 16'({key_error, digit_count}), 16'b1_01);
        key(4'h7);
        chk("invalid_err", 16'(key_error), 16'd1);
        key(4'hC);
        chk("clear", 16'({digit_count, pif.password_1}), 16'd0);

        // Timeout and sensor drop
        key(4'd1);
        for (int i = 0; i < TO; i++) step(1, 0, 4'h0, 0, 0, 0);
        chk("timeout_clr", 16'({digit_count, pif.password_1}), 16'd0);
        key(4'd1);
        step(0, 0, 4'h0, 0, 0, 0);
        chk("sensor_drop", 16'(digit_count), 16'd0);

        // Consecutive rejects
        entry(4'd0, 4'd1, 1);
        entry(4'd1, 4'd1, 0);
        entry(4'd2, 4'd1, 0);
        entry(4'd3, 4'd1, 0);
        chk("lock_after_rejects", 16'(locked), 16'(LOCK_EXP));
        for (int i = 0; i < LK + 4; i++) step(1, $urandom_range(0, 1), 4'($urandom_range(0, 3)), 1, 0, 0);
        chk("lock_release", 16'(locked), 16'd0);
        entry(4'd2, 4'd2, 1);

        // Reset while presenting
        step(1, 0, 4'h0, 0, 0, 0);
        key(4'd3); key(4'd3);
        step(1, 1, 4'hE, 0, 0, 0);
        chk("pre_reset_valid", 16'(pif.pwd_valid), 16'd1);
        rst = 1'b1;
        step(1, 0, 4'h0, 0, 0, 0);
        chk("reset_in_send", 16'(dut_outs), 16'h0);
        rst = 1'b0;

        // Randomized segments with varying key and accept rates
        begin
            bit s;
            s = 1'b1;
            for (int seg = 0; seg < 40; seg++) begin
                int kp, okp;
                case ($urandom_range(0, 2))
                    0: kp = 0;
                    1: kp = 8;
                    default: kp = 35;
                endcase
                okp = $urandom_range(0, 1) ? 60 : 0;
                for (int i = 0; i < 100; i++) begin
                    logic [3:0] c;
                    int r;
                    rst = ($urandom_range(0, 599) == 0);
                    if ($urandom_range(0, 99) < 2) s = ~s;
                    r = $urandom_range(0, 99);
                    if (r < 60)      c = 4'($urandom_range(0, 3));
                    else if (r < 78) c = 4'hE;
                    else if (r < 86) c = 4'hC;
                    else begin
                        c = 4'($urandom_range(4, 15));
                        if (c == 4'hC || c == 4'hE) c = 4'h7;
                    end
                    step(s, ($urandom_range(0, 99) < kp), c, $urandom_range(0, 1),
                         ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < okp));
                end
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
